// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared state encodings and helpers for the SRAM-to-UART dump path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_sram_tx_interface_pkg;

    typedef enum logic [2:0] {
        S_TXI_IDLE,
        S_TXI_RD_ADDR,
        S_TXI_RD_W1,
        S_TXI_RD_W2,
        S_TXI_SEND_HI,
        S_TXI_SEND_LO,
        S_TXI_DONE
    } tx_if_state_type;

    typedef enum logic [2:0] {
        S_TOP_IDLE,
        S_UART_RX,
        S_M1,
        S_M2,
        S_VGA,
        S_UART_TX
    } top_state_type;

    // Fixed SRAM read latency in cycles (address cycle n -> data cycle n+2).
    localparam int SRAM_RD_LATENCY = 2;

    // Select the byte of a 16-bit SRAM word; the high byte goes on the line first.
    function automatic logic [7:0] word_byte(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// Latency: first start-bit cycle follows the Load cycle; one idle-high Ready cycle after each stop bit.
// Backpressure: Ready low while a frame is on the line; Load is ignored unless Ready.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       Load,
    input  logic [7:0] Byte,
    output logic       Ready,
    output logic       TX
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              r_active;
    logic [BAUD_W-1:0] r_baud;
    logic [3:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_tx;

    // Frame sequencer: bit index 0 is the start bit, 1..8 data, 9 the stop bit.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_shift  <= 8'h00;
            r_tx     <= 1'b1;
        end else if (!r_active) begin
            r_tx <= 1'b1;
            if (Load) begin
                r_active <= 1'b1;
                r_tx     <= 1'b0;
                r_shift  <= Byte;
                r_bit    <= 4'd0;
                r_baud   <= '0;
            end
        end else if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == 4'd9) begin
                r_active <= 1'b0;
                r_tx     <= 1'b1;
            end else begin
                r_bit <= r_bit + 4'd1;
                if (r_bit == 4'd8) begin
                    r_tx <= 1'b1;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b0, r_shift[7:1]};
                end
            end
        end else begin
            r_baud <= r_baud + 1'b1;
        end
    end

    assign Ready = !r_active;
    assign TX    = r_tx;

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Streams Word_count SRAM words out on UART_TX_O, high byte first, with the next word prefetched.
// Latency: first start bit 4 cycles after the Start edge; frames back-to-back every 10*CLKS_PER_BIT+1 cycles.
// Backpressure: none towards SRAM (fixed 2-cycle reads); Start ignored while Busy, Abort ends after the current byte.
module uart_sram_tx_interface
    import uart_sram_tx_interface_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 18
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] SRAM_start_address,
    input  logic [ADDR_W-1:0] Word_count,
    input  logic [15:0]       SRAM_read_data,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic              SRAM_we_n,
    output logic              UART_TX_O,
    output logic              Busy,
    output logic              Done
);

    tx_if_state_type   r_state;
    logic              r_start_q;
    logic              r_abort;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_words;
    logic [15:0]       r_word;
    logic [15:0]       r_next;
    logic              r_have_next;
    logic [1:0]        r_pf_cnt;
    logic              r_busy;
    logic              r_done;

    logic              w_ready;
    logic              w_tx;
    logic              w_load;
    logic [7:0]        w_byte;
    logic              w_abort;

    // An abort seen this cycle counts immediately so it can stop the very next load.
    assign w_abort = r_abort | Abort;

    // Serializer load: first byte straight from SRAM data, later bytes from the word/prefetch registers.
    always_comb begin
        w_load = 1'b0;
        w_byte = word_byte(r_word, 1'b0);
        case (r_state)
            S_TXI_RD_W2: begin
                if (!w_abort) begin
                    w_load = 1'b1;
                    w_byte = word_byte(SRAM_read_data, 1'b1);
                end
            end
            S_TXI_SEND_HI: begin
                if (w_ready && !w_abort) begin
                    w_load = 1'b1;
                    w_byte = word_byte(r_word, 1'b0);
                end
            end
            S_TXI_SEND_LO: begin
                if (w_ready && !w_abort && r_have_next) begin
                    w_load = 1'b1;
                    w_byte = word_byte(r_next, 1'b1);
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // Transfer FSM: initial read, then alternate hi/lo frames while the next word is prefetched.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_TXI_IDLE;
            r_start_q   <= 1'b0;
            r_abort     <= 1'b0;
            r_addr      <= '0;
            r_words     <= '0;
            r_word      <= 16'h0000;
            r_next      <= 16'h0000;
            r_have_next <= 1'b0;
            r_pf_cnt    <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_start_q <= Start;
            if (r_state != S_TXI_IDLE && Abort) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                S_TXI_IDLE: begin
                    r_abort <= 1'b0;
                    r_done  <= 1'b0;
                    if (Start && !r_start_q) begin
                        if (Word_count == '0) begin
                            r_state <= S_TXI_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_TXI_RD_ADDR;
                            r_busy  <= 1'b1;
                            r_addr  <= SRAM_start_address;
                            r_words <= Word_count;
                        end
                    end
                end
                S_TXI_RD_ADDR: r_state <= S_TXI_RD_W1;
                S_TXI_RD_W1:   r_state <= S_TXI_RD_W2;
                S_TXI_RD_W2: begin
                    r_word  <= SRAM_read_data;
                    r_words <= r_words - 1'b1;
                    if (w_abort) begin
                        r_state <= S_TXI_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_TXI_SEND_HI;
                    end
                end
                S_TXI_SEND_HI: begin
                    if (w_ready) begin
                        if (w_abort) begin
                            r_state <= S_TXI_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_TXI_SEND_LO;
                            if (r_words != '0) begin
                                r_addr   <= r_addr + 1'b1;
                                r_pf_cnt <= 2'(SRAM_RD_LATENCY + 1);
                            end
                        end
                    end
                end
                S_TXI_SEND_LO: begin
                    if (r_pf_cnt != 2'd0) begin
                        r_pf_cnt <= r_pf_cnt - 2'd1;
                    end
                    if (r_pf_cnt == 2'd1) begin
                        r_next      <= SRAM_read_data;
                        r_have_next <= 1'b1;
                        r_words     <= r_words - 1'b1;
                    end
                    if (w_ready) begin
                        if (w_abort || !r_have_next) begin
                            r_state <= S_TXI_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_word      <= r_next;
                            r_have_next <= 1'b0;
                            r_state     <= S_TXI_SEND_HI;
                        end
                    end
                end
                S_TXI_DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_have_next <= 1'b0;
                    r_pf_cnt    <= 2'd0;
                    r_state     <= S_TXI_IDLE;
                end
                default: r_state <= S_TXI_IDLE;
            endcase
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .CLOCK_50_I(CLOCK_50_I),
        .resetn    (resetn),
        .Load      (w_load),
        .Byte      (w_byte),
        .Ready     (w_ready),
        .TX        (w_tx)
    );

    assign SRAM_address = r_addr;
    assign SRAM_we_n    = 1'b1;
    assign UART_TX_O    = w_tx;
    assign Busy         = r_busy;
    assign Done         = r_done;

endmodule
